// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus front end: state encoding, bit-slot
// constants and the default device address.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Bit counter value during the acknowledge slot.
    localparam logic [3:0] ACK_BIT        = 4'd9;
    // Bit counter value once all eight data bits of a byte are in.
    localparam logic [3:0] LAST_DATA_BIT  = 4'd8;
    // Default 7-bit device address.
    localparam logic [6:0] DEV_ID_DEFAULT = 7'b1010000;

endpackage

// File: rtl/i2c_bus_front_end_line_filter.sv
// Synchroniser plus glitch filter for one raw bus line. The filtered output
// only follows the synchronised value after FILTER_LEN identical consecutive
// samples, so raw-edge to filtered-edge latency is SYNC_STAGES + FILTER_LEN.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_f
);

    localparam int             CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   filt_r;
    logic                   filt_nxt_s;
    logic                   sync_out_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign line_f     = filt_r;

    // Synchroniser chain; preset high so an idle bus never shows a phantom edge at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_in};
        end
    end

    // Count consecutive samples that disagree with the filtered value; flip once the run is long enough.
    always_comb begin
        cnt_nxt_s  = '0;
        filt_nxt_s = filt_r;
        if (sync_out_s != filt_r) begin
            if (cnt_r == CNT_LAST) begin
                filt_nxt_s = sync_out_s;
                cnt_nxt_s  = '0;
            end else begin
                cnt_nxt_s  = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Filter state register; filtered line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            filt_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nxt_s;
            filt_r <= filt_nxt_s;
        end
    end

endmodule

// File: rtl/i2c_bus_front_end.sv
// I2C bus front end: filters SCL/SDA, detects START/STOP, counts bits,
// deserialises bytes and captures the R/W bit and address match of the
// first byte after each START.
module i2c_bus_front_end
    import i2c_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter logic [6:0] DEV_ID      = DEV_ID_DEFAULT
) (
    input  logic       CLK,
    input  logic       RSTbar,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SCL_f,
    output logic       SDA_f,
    output logic       SCL_RISE,
    output logic       SCL_FALL,
    output logic       START,
    output logic       STOP,
    output logic       START_P,
    output logic       STOP_P,
    output logic       WR,
    output logic       WR_VALID,
    output logic       ADDR_MATCH,
    output logic [3:0] BIT_CNT,
    output logic [7:0] RX_BYTE,
    output logic       BYTE_DONE,
    output logic       BUS_BUSY
);

    logic scl_f_s, sda_f_s;
    logic scl_prev_r, sda_prev_r;
    logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s;
    logic [7:0] byte_s;

    state_t     state_r,     state_nxt_s;
    logic [3:0] bit_cnt_r,   bit_cnt_nxt_s;
    logic [6:0] shift_r,     shift_nxt_s;
    logic [7:0] rx_byte_r,   rx_byte_nxt_s;
    logic       wr_r,        wr_nxt_s;
    logic       wr_valid_r,  wr_valid_nxt_s;
    logic       match_r,     match_nxt_s;
    logic       start_r,     start_nxt_s;
    logic       stop_r,      stop_nxt_s;
    logic       busy_r,      busy_nxt_s;
    logic       start_p_r,   start_p_nxt_s;
    logic       stop_p_r,    stop_p_nxt_s;
    logic       done_r,      done_nxt_s;
    logic       scl_rise_r,  scl_fall_r;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (CLK),
        .rst_n   (RSTbar),
        .line_in (SCL_in),
        .line_f  (scl_f_s)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (CLK),
        .rst_n   (RSTbar),
        .line_in (SDA_in),
        .line_f  (sda_f_s)
    );

    // A START/STOP needs SCL high in both cycles, so a simultaneous SCL/SDA change never qualifies.
    assign scl_rise_s  =  scl_f_s & ~scl_prev_r;
    assign scl_fall_s  = ~scl_f_s &  scl_prev_r;
    assign start_det_s =  scl_prev_r & scl_f_s &  sda_prev_r & ~sda_f_s;
    assign stop_det_s  =  scl_prev_r & scl_f_s & ~sda_prev_r &  sda_f_s;
    assign byte_s      = {shift_r, sda_f_s};

    // Next-state and next-output logic for the bus protocol state machine.
    always_comb begin
        state_nxt_s    = state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        rx_byte_nxt_s  = rx_byte_r;
        wr_nxt_s       = wr_r;
        wr_valid_nxt_s = wr_valid_r;
        match_nxt_s    = match_r;
        start_nxt_s    = start_r;
        stop_nxt_s     = stop_r;
        busy_nxt_s     = busy_r;
        start_p_nxt_s  = 1'b0;
        stop_p_nxt_s   = 1'b0;
        done_nxt_s     = 1'b0;
        if (start_det_s) begin
            start_nxt_s    = 1'b1;
            stop_nxt_s     = 1'b0;
            start_p_nxt_s  = 1'b1;
            busy_nxt_s     = 1'b1;
            bit_cnt_nxt_s  = 4'd0;
            wr_valid_nxt_s = 1'b0;
            shift_nxt_s    = 7'd0;
            state_nxt_s    = ST_ADDR;
        end else if (stop_det_s) begin
            stop_nxt_s    = 1'b1;
            start_nxt_s   = 1'b0;
            stop_p_nxt_s  = 1'b1;
            busy_nxt_s    = 1'b0;
            bit_cnt_nxt_s = 4'd0;
            state_nxt_s   = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_ADDR, ST_DATA: begin
                    if (scl_rise_s) begin
                        if (bit_cnt_r < LAST_DATA_BIT) begin
                            shift_nxt_s   = byte_s[6:0];
                            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                            if (bit_cnt_r == (LAST_DATA_BIT - 4'd1)) begin
                                rx_byte_nxt_s = byte_s;
                                done_nxt_s    = 1'b1;
                                if (state_r == ST_ADDR) begin
                                    wr_nxt_s       = ~sda_f_s;
                                    match_nxt_s    = (shift_r == DEV_ID);
                                    wr_valid_nxt_s = 1'b1;
                                end else begin
                                    wr_nxt_s = wr_r;
                                end
                            end else begin
                                done_nxt_s = 1'b0;
                            end
                        end else if (bit_cnt_r == LAST_DATA_BIT) begin
                            bit_cnt_nxt_s = ACK_BIT;
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r;
                        end
                    end else if (scl_fall_s && (bit_cnt_r == ACK_BIT)) begin
                        bit_cnt_nxt_s = 4'd0;
                        if (state_r == ST_ADDR) begin
                            state_nxt_s = ST_DATA;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 7'd0;
            rx_byte_r  <= 8'h00;
            wr_r       <= 1'b0;
            wr_valid_r <= 1'b0;
            match_r    <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            busy_r     <= 1'b0;
            start_p_r  <= 1'b0;
            stop_p_r   <= 1'b0;
            done_r     <= 1'b0;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
        end else begin
            scl_prev_r <= scl_f_s;
            sda_prev_r <= sda_f_s;
            state_r    <= state_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            rx_byte_r  <= rx_byte_nxt_s;
            wr_r       <= wr_nxt_s;
            wr_valid_r <= wr_valid_nxt_s;
            match_r    <= match_nxt_s;
            start_r    <= start_nxt_s;
            stop_r     <= stop_nxt_s;
            busy_r     <= busy_nxt_s;
            start_p_r  <= start_p_nxt_s;
            stop_p_r   <= stop_p_nxt_s;
            done_r     <= done_nxt_s;
            scl_rise_r <= scl_rise_s;
            scl_fall_r <= scl_fall_s;
        end
    end

    assign SCL_f      = scl_f_s;
    assign SDA_f      = sda_f_s;
    assign SCL_RISE   = scl_rise_r;
    assign SCL_FALL   = scl_fall_r;
    assign START      = start_r;
    assign STOP       = stop_r;
    assign START_P    = start_p_r;
    assign STOP_P     = stop_p_r;
    assign WR         = wr_r;
    assign WR_VALID   = wr_valid_r;
    assign ADDR_MATCH = match_r;
    assign BIT_CNT    = bit_cnt_r;
    assign RX_BYTE    = rx_byte_r;
    assign BYTE_DONE  = done_r;
    assign BUS_BUSY   = busy_r;

endmodule

// File: tb/tb_i2c_bus_front_end.sv
// Scoreboard bench for i2c_bus_front_end: bus tasks push the events a
// correct front end must report; a monitor pops them as the DUT pulses.
module tb_i2c_bus_front_end;

    localparam logic [6:0] DEV = 7'b1010000;

    logic       CLK = 1'b0;
    logic       RSTbar = 1'b0;
    logic       SCL_in = 1'b1;
    logic       SDA_in = 1'b1;
    logic       SCL_f, SDA_f, SCL_RISE, SCL_FALL, START, STOP, START_P, STOP_P;
    logic       WR, WR_VALID, ADDR_MATCH, BYTE_DONE, BUS_BUSY;
    logic [3:0] BIT_CNT;
    logic [7:0] RX_BYTE;

    always #5 CLK = ~CLK;

    i2c_bus_front_end #(.SYNC_STAGES(2), .FILTER_LEN(3), .DEV_ID(DEV)) dut (
        .CLK        (CLK),
        .RSTbar     (RSTbar),
        .SCL_in     (SCL_in),
        .SDA_in     (SDA_in),
        .SCL_f      (SCL_f),
        .SDA_f      (SDA_f),
        .SCL_RISE   (SCL_RISE),
        .SCL_FALL   (SCL_FALL),
        .START      (START),
        .STOP       (STOP),
        .START_P    (START_P),
        .STOP_P     (STOP_P),
        .WR         (WR),
        .WR_VALID   (WR_VALID),
        .ADDR_MATCH (ADDR_MATCH),
        .BIT_CNT    (BIT_CNT),
        .RX_BYTE    (RX_BYTE),
        .BYTE_DONE  (BYTE_DONE),
        .BUS_BUSY   (BUS_BUSY)
    );

    typedef enum int {EV_START = 0, EV_STOP = 1, EV_BYTE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        logic       wr;
        logic       wr_valid;
        logic       match;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    logic m_wr = 1'b0, m_wr_valid = 1'b0, m_match = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every pulse from the DUT must match the oldest expected event.
    always @(negedge CLK) begin
        if (RSTbar && (START_P || STOP_P || BYTE_DONE)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({START_P, STOP_P, BYTE_DONE}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (START_P) begin
                    check("event_kind", 32'(EV_START), 32'(mon_e.kind));
                    check("start_levels", 32'({START, STOP, BUS_BUSY, WR_VALID, BIT_CNT}), 32'({1'b1, 1'b0, 1'b1, 1'b0, 4'd0}));
                end else if (STOP_P) begin
                    check("event_kind", 32'(EV_STOP), 32'(mon_e.kind));
                    check("stop_levels", 32'({STOP, START, BUS_BUSY, BIT_CNT}), 32'({1'b1, 1'b0, 1'b0, 4'd0}));
                    check("stop_wr_hold", 32'({WR, WR_VALID}), 32'({mon_e.wr, mon_e.wr_valid}));
                end else begin
                    check("event_kind", 32'(EV_BYTE), 32'(mon_e.kind));
                    check("rx_byte", 32'(RX_BYTE), 32'(mon_e.data));
                    check("byte_wr_match", 32'({WR, WR_VALID, ADDR_MATCH}), 32'({mon_e.wr, mon_e.wr_valid, mon_e.match}));
                    check("byte_bit_cnt", 32'(BIT_CNT), 32'd8);
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"},
              32'({SCL_f, SDA_f, SCL_RISE, SCL_FALL, START, STOP, START_P, STOP_P,
                   WR, WR_VALID, ADDR_MATCH, BYTE_DONE, BUS_BUSY}),
              32'(13'b1100000000000));
        check({tag, "_bit_cnt"}, 32'(BIT_CNT), 32'd0);
        check({tag, "_rx_byte"}, 32'(RX_BYTE), 32'd0);
    endtask

    task automatic bus_start();
        m_wr_valid = 1'b0;
        exp_q.push_back('{kind: EV_START, data: 8'h00, wr: m_wr, wr_valid: 1'b0, match: m_match});
        if (SCL_in == 1'b0) begin
            wclk(5);
            SDA_in = 1'b1;
            wclk(5);
            SCL_in = 1'b1;
            wclk(10);
        end
        SDA_in = 1'b0;
        wclk(10);
        SCL_in = 1'b0;
    endtask

    task automatic bus_bit(input logic b);
        wclk(5);
        SDA_in = b;
        wclk(5);
        SCL_in = 1'b1;
        wclk(10);
        SCL_in = 1'b0;
    endtask

    task automatic bus_byte(input logic [7:0] b, input bit is_addr);
        if (is_addr) begin
            m_wr       = ~b[0];
            m_wr_valid = 1'b1;
            m_match    = (b[7:1] == DEV);
        end
        exp_q.push_back('{kind: EV_BYTE, data: b, wr: m_wr, wr_valid: m_wr_valid, match: m_match});
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic bus_stop();
        exp_q.push_back('{kind: EV_STOP, data: 8'h00, wr: m_wr, wr_valid: m_wr_valid, match: m_match});
        wclk(5);
        SDA_in = 1'b0;
        wclk(5);
        SCL_in = 1'b1;
        wclk(10);
        SDA_in = 1'b1;
        wclk(20);
    endtask

    // Watchdog: the run must end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   glitch_err;
        logic [7:0] a;

        // Reset held, then released onto an idle bus.
        wclk(5);
        check_reset_outputs("in_reset");
        RSTbar = 1'b1;
        wclk(50);
        check_reset_outputs("idle");

        // Write transaction to our address, one data byte.
        bus_start();
        bus_byte(8'hA0, 1'b1);
        bus_byte(8'h3C, 1'b0);
        bus_stop();

        // Read to our address, then a foreign address.
        bus_start();
        bus_byte(8'hA1, 1'b1);
        bus_stop();
        bus_start();
        bus_byte(8'hB1, 1'b1);
        bus_stop();

        // Repeated START after four bits of a data byte.
        bus_start();
        bus_byte(8'hA1, 1'b1);
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
        check("partial_bit_cnt", 32'(BIT_CNT), 32'd4);
        bus_start();
        bus_byte(8'hA0, 1'b1);
        bus_stop();

        // Short SDA glitches while SCL is high must be swallowed.
        glitch_err = 0;
        SDA_in = 1'b0; wclk(1); SDA_in = 1'b1;
        for (int i = 0; i < 12; i++) begin wclk(1); if (SDA_f !== 1'b1) glitch_err++; end
        SDA_in = 1'b0; wclk(2); SDA_in = 1'b1;
        for (int i = 0; i < 12; i++) begin wclk(1); if (SDA_f !== 1'b1) glitch_err++; end
        check("glitch_sda_f", 32'(glitch_err), 32'd0);

        // Filter latency: raw SCL fall shows on SCL_f after exactly five clocks.
        SCL_in = 1'b0;
        wclk(4);
        check("latency_before", 32'(SCL_f), 32'd1);
        wclk(1);
        check("latency_at", 32'(SCL_f), 32'd0);
        wclk(1);
        check("scl_fall_pulse", 32'(SCL_FALL), 32'd1);
        SCL_in = 1'b1;
        wclk(10);

        // Asynchronous reset in the middle of a byte.
        bus_start();
        for (int i = 0; i < 5; i++) bus_bit(1'($urandom_range(0, 1)));
        check("pre_reset_bit_cnt", 32'(BIT_CNT), 32'd5);
        #2;
        RSTbar = 1'b0;
        SCL_in = 1'b1;
        SDA_in = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        m_wr = 1'b0; m_wr_valid = 1'b0; m_match = 1'b0;
        wclk(3);
        RSTbar = 1'b1;
        wclk(20);

        // Randomised transactions.
        for (int t = 0; t < 12; t++) begin
            bus_start();
            a = ($urandom_range(0, 1) == 0) ? {DEV, 1'($urandom_range(0, 1))} : 8'($urandom);
            bus_byte(a, 1'b1);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) bus_byte(8'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) bus_bit(1'($urandom_range(0, 1)));
                bus_start();
                a = ($urandom_range(0, 1) == 0) ? {DEV, 1'($urandom_range(0, 1))} : 8'($urandom);
                bus_byte(a, 1'b1);
            end
            bus_stop();
        end

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            wclk(1);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_bus_front_end.md
Name: i2c_bus_front_end

Overview:
- Upstream stage of the flash Controller. Oversamples the raw I2C SCL/SDA lines on a system clock and glitch-filters them.
- Detects START, repeated START and STOP conditions.
- Counts bits and deserialises bytes.
- Extracts the R/W bit of the first byte after each START and drives the START, STOP and WR levels the Controller consumes.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per line (minimum 2).
- FILTER_LEN, 3: consecutive identical samples needed before a filtered line changes.
- DEV_ID, 7'b1010000: 7-bit device address compared against the first byte.

Ports:
- CLK  in  1  system clock; oversamples SCL at 8x or more.
- RSTbar  in  1  asynchronous active-low reset.
- SCL_in  in  1  raw bus clock.
- SDA_in  in  1  raw bus data.
- SCL_f  out  1  filtered SCL.
- SDA_f  out  1  filtered SDA.
- SCL_RISE  out  1  one-CLK pulse on each filtered SCL rising edge.
- SCL_FALL  out  1  one-CLK pulse on each filtered SCL falling edge.
- START  out  1  level; set on START or repeated START, cleared on STOP.
- STOP  out  1  level; set on STOP, cleared on the next START.
- START_P  out  1  one-CLK pulse per START or repeated START.
- STOP_P  out  1  one-CLK pulse per STOP.
- WR  out  1  1 = write transaction; equals ~R/W bit of the first byte.
- WR_VALID  out  1  WR is meaningful.
- ADDR_MATCH  out  1  first byte [7:1] == DEV_ID; valid while WR_VALID.
- BIT_CNT  out  4  bits received in the current byte, 0..9.
- RX_BYTE  out  8  last completed byte, MSB first.
- BYTE_DONE  out  1  one-CLK pulse when RX_BYTE updates.
- BUS_BUSY  out  1  1 between START and STOP.

Behaviour:
- Reset values (asynchronous, RSTbar=0):
  - all flops cleared; filtered lines preset to 1 (idle bus);
  - START=0, STOP=0, WR=0, WR_VALID=0, ADDR_MATCH=0, BIT_CNT=0, RX_BYTE=8'h00, BUS_BUSY=0;
  - all pulse outputs 0; state IDLE.
- Synchroniser and filter:
  - each line passes SYNC_STAGES flops;
  - the filtered value takes the synchronised value only after FILTER_LEN equal consecutive samples;
  - glitches shorter than FILTER_LEN CLKs are ignored;
  - latency from raw edge to filtered edge = SYNC_STAGES + FILTER_LEN CLKs.
- Edge detection:
  - SCL_RISE/SCL_FALL compare SCL_f with its previous-cycle value.
  - START condition: SDA_f 1->0 with SCL_f 1 in both the previous and current cycle.
  - STOP condition: SDA_f 0->1 under the same SCL_f rule.
  - If SCL_f and SDA_f change in the same cycle, no condition is detected.
- State machine, states IDLE, ADDR, DATA:
  - Any state, on START: START=1, STOP=0, START_P=1, BUS_BUSY=1, BIT_CNT=0, WR_VALID=0, shift register cleared, go to ADDR. This aborts any partial byte.
  - Any state, on STOP: STOP=1, START=0, STOP_P=1, BUS_BUSY=0, BIT_CNT=0, go to IDLE. The partial byte is discarded; WR and WR_VALID hold their values.
  - IDLE: SCL edges are ignored.
  - ADDR and DATA, on SCL_RISE with BIT_CNT<8: shift SDA_f in at the LSB and increment BIT_CNT.
  - When BIT_CNT reaches 8: RX_BYTE and BYTE_DONE update in the same cycle as the 8th rising edge.
  - 9th SCL_RISE (ACK slot): BIT_CNT goes to 9 and no data is shifted.
  - SCL_FALL with BIT_CNT==9: BIT_CNT wraps to 0.
  - ADDR, on the 8th rising edge: WR = ~shifted_bit0, ADDR_MATCH = (byte[7:1]==DEV_ID), WR_VALID=1, then go to DATA once BIT_CNT wraps.
  - DATA: bytes repeat indefinitely; WR is unchanged.
- Reset mid-transaction returns everything to reset values immediately.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2;
  - ACK_BIT=4'd9;
  - the default DEV_ID.
- One sub-module, i2c_line_filter: synchroniser plus glitch filter, parameterised by SYNC_STAGES and FILTER_LEN, instantiated once for SCL and once for SDA.

Test Plan:
1. Reset released, idle bus (SCL=SDA=1) held for 50 CLK -> all outputs at reset values, SCL_f=SDA_f=1.
2. START, then byte 0xA0, ACK, data byte 0x3C, STOP ->
   - START_P once, START=1;
   - after the 8th rise: RX_BYTE=0xA0, WR=1, WR_VALID=1, ADDR_MATCH=1;
   - then RX_BYTE=0x3C with BYTE_DONE pulsed twice in total;
   - on STOP: STOP=1, START=0, BUS_BUSY=0.
3. START, byte 0xA1 -> WR=0, ADDR_MATCH=1. Byte 0xB1 instead -> ADDR_MATCH=0.
4. Repeated START after 4 bits of a data byte -> BIT_CNT=0, WR_VALID=0, state ADDR, START_P pulses, no BYTE_DONE. Next byte 0xA0 -> WR=1.
5. 1-CLK and 2-CLK low glitches on SDA while SCL is high, with FILTER_LEN=3 -> no START_P, no STOP_P, SDA_f stays 1.
6. RSTbar asserted mid-byte (BIT_CNT=5) -> all outputs return to reset values in the same cycle, without waiting for a CLK edge.
